// File: rtl/pcs_pkg.sv
// Shared PCS definitions: transmit controller state encoding and the
// gearbox / alignment-marker constants used by gearbox_tx and am_tx.
package pcs_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } pcs_tx_ctrl_state_e;

   // Sequence value of the full (no-accept) gearbox cycle for a 64b/66b lane.
   localparam int PCS_SEQ_MAX   = 32;
   // Default block slots per alignment-marker period, marker included.
   localparam int PCS_AM_PERIOD = 16384;

endpackage

// File: rtl/pcs_tx_ctrl_if.sv
// MAC/lane-side control bundle of the PCS transmit controller.
// master: the controller; slave: MAC handshake plus lane consumers.
interface pcs_tx_ctrl_if #(
   parameter int SEQ_W = 6
);
   logic             en_i;
   logic [SEQ_W-1:0] seq_o;
   logic             gb_accept_o;
   logic             scram_v_o;
   logic             marker_v_o;
   logic             force_idle_o;
   logic             ready_o;

   modport master (
      input  en_i,
      output seq_o, gb_accept_o, scram_v_o, marker_v_o, force_idle_o, ready_o
   );

   modport slave (
      output en_i,
      input  seq_o, gb_accept_o, scram_v_o, marker_v_o, force_idle_o, ready_o
   );
endinterface

// File: rtl/pcs_tx_seq_cnt.sv
// Gearbox sequence counter: wraps SEQ_MAX -> 0 every cycle and flags the
// accept slot (every cycle except the full one). Shared with the RX gearbox.
module pcs_tx_seq_cnt #(
   parameter int SEQ_W   = 6,
   parameter int SEQ_MAX = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic [SEQ_W-1:0] seq_o,
   output logic             accept_o
);
   localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_MAX);

   logic [SEQ_W-1:0] seq_q;
   logic [SEQ_W-1:0] seq_d;

   // Next sequence value with wrap at the full cycle.
   always_comb begin
      seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
   end

   // Sequence register; free-running outside reset.
   always_ff @(posedge clk) begin
      if (reset) seq_q <= '0;
      else       seq_q <= seq_d;
   end

   assign seq_o    = seq_q;
   assign accept_o = (seq_q != SEQ_LAST);
endmodule

// File: rtl/pcs_tx_ctrl.sv
// PCS transmit sequencing controller: gearbox sequence, marker slots,
// scrambler gating, startup idle fill and MAC ready.
// Build option: define PCS_TX_CTRL_AM_EN for 40G alignment-marker scheduling;
// left undefined (10G) no markers are generated and AM_PERIOD is unused.
module pcs_tx_ctrl
   import pcs_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int HEAD_W    = 2,
   parameter int SEQ_W     = $clog2(DATA_W/HEAD_W + 1),
   parameter int SEQ_MAX   = DATA_W/HEAD_W,
   parameter int AM_PERIOD = PCS_AM_PERIOD,
   parameter int FILL_N    = 64
) (
   input logic           clk,
   input logic           reset,
   pcs_tx_ctrl_if.master bus
);
   localparam int FILL_W = $clog2(FILL_N + 1);

   pcs_tx_ctrl_state_e state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [SEQ_W-1:0]   seq;
   logic               accept;
   logic               act;
   logic               marker;
   logic               slot;

   pcs_tx_seq_cnt #(
      .SEQ_W   (SEQ_W),
      .SEQ_MAX (SEQ_MAX)
   ) u_seq (
      .clk      (clk),
      .reset    (reset),
      .seq_o    (seq),
      .accept_o (accept)
   );

   // A slot is live only once the link has left INIT; data slots exclude markers.
   assign act  = accept & (state_q != INIT);
   assign slot = act & ~marker;

`ifdef PCS_TX_CTRL_AM_EN
   localparam int AM_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
   logic [AM_W-1:0] am_q, am_d;

   // Marker slot counter: held at 0 in INIT so the first live slot is a marker;
   // frozen during the full cycle so markers defer to the next accept slot.
   always_comb begin
      am_d = am_q;
      if (state_q == INIT) am_d = '0;
      else if (act)        am_d = (am_q == AM_W'(AM_PERIOD - 1)) ? '0 : am_q + 1'b1;
   end

   // Marker counter register.
   always_ff @(posedge clk) begin
      if (reset) am_q <= '0;
      else       am_q <= am_d;
   end

   assign marker = act & (am_q == '0);
`else
   assign marker = 1'b0;
`endif

   // Configuration values not referenced by every build variant.
   logic unused_cfg;
   assign unused_cfg = (SEQ_MAX != PCS_SEQ_MAX) | (AM_PERIOD < 2);

   // Link FSM next state and fill counting; en_i low always returns to INIT.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      case (state_q)
         INIT: begin
            fill_d = '0;
            if (bus.en_i) state_d = FILL;
         end
         FILL: begin
            if (slot) begin
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_W'(FILL_N - 1)) state_d = RUN;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
      if (!bus.en_i) state_d = INIT;
   end

   // FSM and fill counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   assign bus.seq_o        = seq;
   assign bus.gb_accept_o  = accept;
   assign bus.marker_v_o   = marker;
   assign bus.scram_v_o    = slot;
   assign bus.force_idle_o = (state_q == FILL);
   assign bus.ready_o      = (state_q == RUN) & slot;
endmodule

// File: tb/tb_pcs_tx_ctrl.sv
// Scoreboard bench for pcs_tx_ctrl (FILL_N = 4, AM_PERIOD = 8). Works with or
// without PCS_TX_CTRL_AM_EN; the reference model follows the same macro.
module tb_pcs_tx_ctrl;
   localparam int FILL_N = 4;
   localparam int AMP    = 8;
   localparam int SMAX   = 32;
`ifdef PCS_TX_CTRL_AM_EN
   localparam bit AM_ON = 1'b1;
`else
   localparam bit AM_ON = 1'b0;
`endif

   typedef struct {
      int seq;
      bit acc;
      bit scr;
      bit mk;
      bit idle;
      bit rdy;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   // reference model state: st 0=INIT 1=FILL 2=RUN
   int m_seq = 0, m_st = 0, m_am = 0, m_fill = 0;
   bit cur_r, cur_e;

   always #5 clk = ~clk;

   pcs_tx_ctrl_if #(.SEQ_W(6)) bus ();

   pcs_tx_ctrl #(
      .DATA_W    (64),
      .HEAD_W    (2),
      .AM_PERIOD (AMP),
      .FILL_N    (FILL_N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t o;
      bit act;
      act    = (m_seq != SMAX) && (m_st != 0);
      o.seq  = m_seq;
      o.acc  = (m_seq != SMAX);
      o.mk   = AM_ON && act && (m_am == 0);
      o.scr  = act && !o.mk;
      o.idle = (m_st == 1);
      o.rdy  = (m_st == 2) && act && !o.mk;
      return o;
   endfunction

   task automatic model_adv(input bit r, input bit e);
      exp_t o;
      int   nst;
      if (r) begin
         m_seq = 0; m_st = 0; m_am = 0; m_fill = 0;
      end else begin
         o = model_out();
         nst = m_st;
         if (!e)                                         nst = 0;
         else if (m_st == 0)                             nst = 1;
         else if (m_st == 1 && o.scr && m_fill == FILL_N-1) nst = 2;
         if (m_st == 0)              m_fill = 0;
         else if (m_st == 1 && o.scr) m_fill = m_fill + 1;
         if (m_st == 0)              m_am = 0;
         else if (o.acc)             m_am = (m_am + 1) % AMP;
         m_seq = (m_seq + 1) % (SMAX + 1);
         m_st  = nst;
      end
   endtask

   // Advance one clock: model takes the edge with the inputs it saw, then the
   // next inputs are applied and the outputs expected for this cycle queued.
   task automatic step(input bit r, input bit e, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         model_adv(cur_r, cur_e);
         cur_r = r; cur_e = e;
         reset = r; bus.en_i = e;
         sb.push_back(model_out());
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check_val("seq_o",        32'(bus.seq_o),        32'(x.seq));
         check_val("gb_accept_o",  32'(bus.gb_accept_o),  32'(x.acc));
         check_val("scram_v_o",    32'(bus.scram_v_o),    32'(x.scr));
         check_val("marker_v_o",   32'(bus.marker_v_o),   32'(x.mk));
         check_val("force_idle_o", 32'(bus.force_idle_o), 32'(x.idle));
         check_val("ready_o",      32'(bus.ready_o),      32'(x.rdy));
      end
   end

   initial begin
      reset    = 1'b1;
      bus.en_i = 1'b0;
      cur_r    = 1'b1;
      cur_e    = 1'b0;
      step(1, 0, 3);     // reset held three cycles
      step(0, 0, 40);    // idle counting, no slots
      step(0, 1, 300);   // enable: fill then steady run with markers
      step(0, 0, 3);     // drop enable in RUN
      step(0, 1, 7);     // re-enable at another gearbox phase
      step(0, 0, 2);
      step(0, 1, 120);
      step(1, 1, 2);     // reset mid-run
      step(0, 1, 80);
      step(0, 0, 5);
      @(negedge clk); #1;
      check_val("queue_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
